// File: rtl/msrv32_lsu_ctrl.sv
// msrv32_lsu_ctrl: load/store unit bus sequencer (IDLE/BUSY/DONE) with bus timeout.
// Define MSRV32_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module msrv32_lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        mem_valid_in,
  input  logic        is_store_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wmask_out,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        done_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d, addr_a;
  logic [3:0]    wmask_q, wmask_d;
  logic [1:0]    size_q, size_d;
  logic          we_q, we_d, uns_q, uns_d, err_q, err_d, mis_q, mis_d, mis_in;
  logic [7:0]    rb;
  logic [15:0]   rh;
`ifdef MSRV32_MISALIGN_TRAP_EN
  assign mis_in = (load_size_in == 2'b01 && addr_in[0]) || (load_size_in[1] && addr_in[1:0] != 2'b00);
`else
  assign mis_in = 1'b0;
`endif
  assign addr_a = load_size_in[1] ? {addr_in[31:2], 2'b00} :
                  load_size_in[0] ? {addr_in[31:1], 1'b0} : addr_in;
  assign rb = dmem_rdata_in[{addr_q[1:0], 3'b000} +: 8];
  assign rh = dmem_rdata_in[{addr_q[1], 4'b0000} +: 16];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    ld_d    = ld_q;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    if (state_q == IDLE && mem_valid_in) begin
      if (mis_in) begin
        state_d = DONE;
        mis_d   = 1'b1;
      end else begin
        state_d = BUSY;
        cnt_d   = '0;
        addr_d  = addr_a;
        we_d    = is_store_in;
        size_d  = load_size_in;
        uns_d   = load_unsigned_in;
        wdata_d = load_size_in[1] ? store_data_in :
                  load_size_in[0] ? {2{store_data_in[15:0]}} : {4{store_data_in[7:0]}};
        wmask_d = !is_store_in   ? 4'b0000 :
                  load_size_in[1] ? 4'b1111 :
                  load_size_in[0] ? (addr_a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_a[1:0];
      end
    end else if (state_q == BUSY) begin
      if (dmem_ack_in) begin
        state_d = DONE;
        if (!we_q)
          ld_d = size_q[1] ? dmem_rdata_in :
                 size_q[0] ? {{16{~uns_q & rh[15]}}, rh} : {{24{~uns_q & rb[7]}}, rb};
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = DONE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      ld_q    <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end
  assign dmem_req_out   = state_q == BUSY;
  assign dmem_we_out    = we_q;
  assign dmem_addr_out  = {addr_q[31:2], 2'b00};
  assign dmem_wdata_out = wdata_q;
  assign dmem_wmask_out = wmask_q;
  // Held in reset, upstream must not be frozen even if it still presents an operation.
  assign stall_out      = reset_n_in & ((state_q == IDLE & mem_valid_in) | (state_q == BUSY));
  assign load_data_out  = ld_q;
  assign done_out       = state_q == DONE;
  assign misaligned_out = mis_q;
  assign bus_err_out    = err_q;
endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// tb_msrv32_lsu_ctrl: transaction-level model with per-cycle output comparison and directed pins.
module tb_msrv32_lsu_ctrl;
  localparam int TO = 16;
  logic        clk = 1'b0, reset_n, mem_valid, is_store, uns, ack;
  logic [31:0] addr, sdata, rdata;
  logic [1:0]  size;
  logic        req, we, stall, done, mis, err;
  logic [31:0] baddr, wdata, ld;
  logic [3:0]  wmask;
  int          checks = 0, failures = 0;
  logic        cmp_en = 1'b0;
  logic        e_req, e_we, e_stall, e_done, e_mis, e_err;
  logic [31:0] e_addr, e_wdata, e_ld;
  logic [3:0]  e_wmask;
  int          req_cnt, stall_cnt;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_wmask;
  logic        obs_we;
  logic [31:0] m_wdata_last;
  logic [3:0]  m_wmask_last;

  msrv32_lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk_in(clk), .reset_n_in(reset_n), .mem_valid_in(mem_valid), .is_store_in(is_store),
    .addr_in(addr), .store_data_in(sdata), .load_size_in(size), .load_unsigned_in(uns),
    .dmem_req_out(req), .dmem_we_out(we), .dmem_addr_out(baddr), .dmem_wdata_out(wdata),
    .dmem_wmask_out(wmask), .dmem_ack_in(ack), .dmem_rdata_in(rdata), .stall_out(stall),
    .load_data_out(ld), .done_out(done), .misaligned_out(mis), .bus_err_out(err));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MSRV32_MISALIGN_TRAP_EN
    return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_mask(input logic st, input logic [1:0] sz, input logic [31:0] a);
    if (!st) return 4'b0000;
    if (sz[1]) return 4'b1111;
    if (sz[0]) return a[1] ? 4'b1100 : 4'b0011;
    return 4'(1 << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
    if (sz[1]) return d;
    if (sz[0]) return {d[15:0], d[15:0]};
    return {d[7:0], d[7:0], d[7:0], d[7:0]};
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    if (sz[1]) return rd;
    sh = sz[0] ? (a[1] ? 16 : 0) : 8 * int'(a[1:0]);
    v = rd >> sh;
    if (sz[0]) return un ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return un ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
  endfunction

  always @(negedge clk) begin
    if (req) begin
      req_cnt++;
      obs_addr = baddr; obs_wdata = wdata; obs_wmask = wmask; obs_we = we;
    end
    if (stall) stall_cnt++;
    if (cmp_en) begin
      chk("req", 32'(req), 32'(e_req));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("done", 32'(done), 32'(e_done));
      chk("misaligned", 32'(mis), 32'(e_mis));
      chk("bus_err", 32'(err), 32'(e_err));
      chk("load_data", ld, e_ld);
      if (e_req) begin
        chk("bus_addr", baddr, e_addr);
        chk("bus_we", 32'(we), 32'(e_we));
        chk("bus_wdata", wdata, e_wdata);
        chk("bus_wmask", 32'(wmask), 32'(e_wmask));
      end
    end
  end

  task automatic set_idle();
    e_req = 1'b0; e_stall = 1'b0; e_done = 1'b0; e_mis = 1'b0; e_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mem_valid = 1'b0; ack = 1'b0; rdata = $urandom; addr = $urandom; sdata = $urandom;
      set_idle();
    end
  endtask

  // wt = BUSY cycles without ack before the ack cycle; wt >= TO means no ack at all
  task automatic run(input logic st, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                     input logic un, input int wt, input logic [31:0] rd);
    logic mm;
    int nb;
    mm = m_mis(sz, a);
    @(posedge clk); #1;
    mem_valid = 1'b1; is_store = st; addr = a; sdata = d; size = sz; uns = un; ack = 1'b0; rdata = $urandom;
    set_idle(); e_stall = 1'b1;
    req_cnt = 0; stall_cnt = 0;
    m_wdata_last = m_wd(sz, d); m_wmask_last = m_mask(st, sz, a);
    if (!mm) begin
      nb = (wt < TO) ? wt + 1 : TO;
      for (int j = 0; j < nb; j++) begin
        @(posedge clk); #1;
        ack = (j == wt); rdata = ack ? rd : $urandom;
        e_req = 1'b1; e_stall = 1'b1;
        e_addr = a & ~32'h3; e_we = st; e_wdata = m_wdata_last; e_wmask = m_wmask_last;
      end
    end
    @(posedge clk); #1;
    ack = 1'b0; mem_valid = 1'($urandom_range(0, 1));
    set_idle(); e_done = 1'b1; e_mis = mm; e_err = !mm && wt >= TO;
    if (!mm && !st && wt < TO) e_ld = m_load(sz, un, a, rd);
  endtask

  initial begin
    reset_n = 1'b0; mem_valid = 1'b0; is_store = 1'b0; uns = 1'b0; ack = 1'b0;
    addr = '0; sdata = '0; size = '0; rdata = '0;
    e_addr = '0; e_wdata = '0; e_wmask = '0; e_we = 1'b0; e_ld = '0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("rst_addr", baddr, 32'h0);
    chk("rst_wmask", 32'(wmask), 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_ld", ld, 32'h0);
    reset_n = 1'b1;
    idle(2);

    run(1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 0, 32'h0);
    chk("w_st_req_cycles", 32'(req_cnt), 32'd1);
    chk("w_st_stall_cycles", 32'(stall_cnt), 32'd2);
    chk("w_st_addr", obs_addr, 32'h100);
    chk("w_st_mask", 32'(obs_wmask), 32'hF);
    chk("w_st_we", 32'(obs_we), 32'h1);
    chk("w_st_done", 32'(done), 32'h1);
    idle(1);

    run(1'b0, 32'h203, 32'h0, 2'b00, 1'b0, 0, 32'h80FFFF7F);
    chk("lb_signed", ld, 32'hFFFFFF80);
    chk("model_lb_signed", e_ld, 32'hFFFFFF80);
    idle(1);
    run(1'b0, 32'h203, 32'h0, 2'b00, 1'b1, 0, 32'h80FFFF7F);
    chk("lb_unsigned", ld, 32'h00000080);
    idle(1);

    run(1'b1, 32'h302, 32'h1234ABCD, 2'b01, 1'b0, 3, 32'h0);
    chk("h_st_req_cycles", 32'(req_cnt), 32'd4);
    chk("h_st_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("h_st_mask", 32'(obs_wmask), 32'hC);
    chk("h_st_wdata", obs_wdata, 32'hABCDABCD);
    chk("model_h_mask", 32'(m_wmask_last), 32'hC);
    idle(1);

    run(1'b0, 32'h400, 32'h0, 2'b10, 1'b0, TO + 5, 32'h0);
    chk("to_req_cycles", 32'(req_cnt), 32'd16);
    chk("to_bus_err", 32'(err), 32'h1);
    chk("to_ld_kept", ld, 32'h00000080);
    idle(1);
    run(1'b0, 32'h404, 32'h0, 2'b10, 1'b0, TO - 1, 32'h5A5A0001);
    chk("ack16_req_cycles", 32'(req_cnt), 32'd16);
    chk("ack16_bus_err", 32'(err), 32'h0);
    chk("ack16_ld", ld, 32'h5A5A0001);
    idle(1);

    run(1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 0, 32'h11223344);
`ifdef MSRV32_MISALIGN_TRAP_EN
    chk("trap_req_cycles", 32'(req_cnt), 32'd0);
    chk("trap_mis", 32'(mis), 32'h1);
    chk("trap_ld_kept", ld, 32'h5A5A0001);
`else
    chk("noalign_addr", obs_addr, 32'h100);
    chk("noalign_mis", 32'(mis), 32'h0);
    chk("noalign_ld", ld, 32'h11223344);
`endif
    idle(1);

    // reset in the second BUSY cycle, with a colliding ack that must be ignored
    @(posedge clk); #1;
    mem_valid = 1'b1; is_store = 1'b0; addr = 32'h500; size = 2'b10; uns = 1'b0; ack = 1'b0;
    set_idle(); e_stall = 1'b1;
    @(posedge clk); #1;
    e_req = 1'b1; e_addr = 32'h500; e_we = 1'b0; e_wdata = m_wd(2'b10, sdata); e_wmask = 4'b0000;
    @(posedge clk); #1;
    reset_n = 1'b0; ack = 1'b1; rdata = 32'hCAFEF00D; e_stall = 1'b0;
    @(posedge clk); #1;
    ack = 1'b0; set_idle(); e_ld = '0;
    #3;
    chk("rst_busy_req", 32'(req), 32'h0);
    chk("rst_busy_stall", 32'(stall), 32'h0);
    chk("rst_busy_done", 32'(done), 32'h0);
    chk("rst_busy_ld", ld, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1; mem_valid = 1'b0;
    idle(2);

    for (int i = 0; i < 60; i++) begin
      int r, wt;
      r = $urandom_range(0, 9);
      wt = (r == 8) ? TO - 1 : (r == 9) ? TO + 3 : r % 5;
      run(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), wt, $urandom);
      idle($urandom_range(0, 2));
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/msrv32_lsu_ctrl.md
MSRV32_LSU_CTRL -- requirements
Module: msrv32_lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: BUSY cycles without dmem_ack_in before the access is aborted.
REQ-002 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n_in  input  1  reset; synchronous, active-low.
REQ-004 mem_valid_in  input  1  execute-stage memory operation present; held stable by upstream while stall_out=1.
REQ-005 is_store_in  input  1  1 = store, 0 = load; sampled with mem_valid_in.
REQ-006 addr_in  input  32  effective address from the execute pipeline register.
REQ-007 store_data_in  input  32  rs2 value for stores.
REQ-008 load_size_in  input  2  access size: 00 = byte, 01 = half, 1x = word.
REQ-009 load_unsigned_in  input  1  1 = zero-extend loads, 0 = sign-extend loads.
REQ-010 dmem_req_out, dmem_we_out  output  1 each  bus request and write enable.
REQ-011 dmem_addr_out  output  32  word-aligned bus address, with bits [1:0]=00.
REQ-012 dmem_wdata_out  output  32  lane-replicated store data.
REQ-013 dmem_wmask_out  output  4  byte-lane write strobes.
REQ-014 dmem_ack_in  input  1  bus completion; dmem_rdata_in (input, 32) is valid in the same cycle.
REQ-015 stall_out  output  1  freezes upstream pipeline registers.
REQ-016 load_data_out  output  32  extended load result, registered.
REQ-017 done_out, misaligned_out, bus_err_out  output  1 each  completion, misaligned-access and timeout status.

Function
REQ-018 The FSM SHALL have three states, IDLE, BUSY and DONE, with transitions as follows:
- IDLE→BUSY when mem_valid_in=1 and the access is aligned; addr, data, size, sign and direction are latched on this edge.
- BUSY→DONE on dmem_ack_in=1 or on timeout.
- DONE→IDLE unconditionally.
REQ-019 stall_out SHALL equal (IDLE & mem_valid_in) | BUSY; it SHALL be 0 in DONE, and mem_valid_in SHALL be ignored in DONE.
REQ-020 dmem_req_out SHALL be 1 exactly in BUSY; dmem_addr_out, dmem_we_out, dmem_wdata_out and dmem_wmask_out SHALL be stable throughout BUSY.
REQ-021 Store mask SHALL be:
- byte: 0001<<addr[1:0]
- half: 0011<<{addr[1],0}
- word: 1111
For loads the mask SHALL be 0000.
REQ-022 Store data SHALL be: byte {4{data[7:0]}}, half {2{data[15:0]}}, word data.
REQ-023 On ack of a load, load_data_out SHALL capture:
- byte: lane addr[1:0]
- half: lane addr[1]
- word: full 32 bits
Sub-word results are sign- or zero-extended per load_unsigned_in. For stores, load_data_out SHALL hold its previous value.
REQ-024 done_out SHALL be 1 for exactly the DONE cycle. The minimum latency is 2 cycles from acceptance to done_out: ack in the first BUSY cycle gives done_out in the following cycle.
REQ-025 A counter SHALL count BUSY cycles; if TIMEOUT cycles elapse without ack, the FSM enters DONE with bus_err_out=1 and load_data_out unchanged.
REQ-026 If ack arrives in the cycle the count reaches TIMEOUT, the ack SHALL take priority and bus_err_out SHALL stay 0.
REQ-027 misaligned_out and bus_err_out SHALL be valid only while done_out=1 and 0 otherwise.

Reset
REQ-028 When reset_n_in=0 at a clock edge, the block SHALL enter IDLE and clear all outputs and the counter to 0, including when reset occurs in BUSY.
REQ-029 dmem_req_out SHALL be 0 from the first edge at which reset is sampled; an ack arriving during reset SHALL be ignored.

Configuration
REQ-030 The macro is MSRV32_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠00, SHALL go IDLE→DONE with misaligned_out=1, issue no bus request, and leave load_data_out unchanged.
- Undefined: misaligned addresses SHALL be forced aligned (half clears bit 0, word clears [1:0]), the access proceeds normally, and misaligned_out SHALL be tied 0.

Verification
REQ-031 Word store to 0x100, data 0xDEADBEEF, ack in the first BUSY cycle → bus cycle shows addr=0x100, mask=1111, we=1; done_out 2 cycles after acceptance; stall_out 0 in DONE.
REQ-032 Byte load from 0x203 with rdata=0x80FF_FF7F and load_unsigned_in=0 → load_data_out=0xFFFFFF80. The same access with load_unsigned_in=1 → 0x00000080.
REQ-033 Half store to 0x302, data 0x1234ABCD, ack after 3 wait cycles → wmask=1100, wdata=0xABCDABCD; req high for 4 cycles; stall_out high for 5 cycles.
REQ-034 Word load with no ack and TIMEOUT=16 → req drops after 16 BUSY cycles, then done_out=1 and bus_err_out=1. A second run with ack in cycle 16 → bus_err_out=0.
REQ-035 With MSRV32_MISALIGN_TRAP_EN defined, word load from 0x101 → no req, misaligned_out=1 with done_out in the cycle after acceptance. Without the macro → bus addr=0x100 and misaligned_out=0.
REQ-036 reset_n_in=0 asserted in the second BUSY cycle → the next cycle shows req=0, stall_out=0 and done_out=0, and the FSM is in IDLE.
